// File: rtl/rv_instr_stream_gen.sv
// RV32IM instruction stimulus source: encodes field writes into a program buffer
// and replays it over a valid/ready stream in sequential, looped or random order.
module rv_instr_stream_gen #(
  parameter int          DEPTH     = 16,
  parameter int          REPEAT_W  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [2:0]          wr_fmt,
  input  logic [6:0]          wr_opcode,
  input  logic [2:0]          wr_funct3,
  input  logic [6:0]          wr_funct7,
  input  logic [4:0]          wr_rd,
  input  logic [4:0]          wr_rs1,
  input  logic [4:0]          wr_rs2,
  input  logic [31:0]         wr_imm,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [AW:0]         count,
  input  logic [REPEAT_W-1:0] repeat_n,
  output logic [31:0]         instr_o,
  output logic [AW-1:0]       instr_idx_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          EW  = AW + 1 + REPEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SEEK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];
  logic [AW-1:0]         ptr_q, ptr_d, idx_q, idx_d;
  logic [REPEAT_W-1:0]   rep_q, rep_d, rep_n_q, rep_n_d;
  logic [EW-1:0]         emit_q, emit_d, total_q, total_d;
  logic [AW:0]           count_q, count_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [31:0]           instr_q, instr_d;
  logic                  valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic                  wr_ok, last_idx;
  logic [31:0]           wr_word;

  function automatic logic [31:0] encode(
    input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [31:0] imm);
    case (fmt)
      3'd0:    return {f7, rs2, rs1, f3, rd, op};
      3'd1:    return {imm[11:0], rs1, f3, rd, op};
      3'd2:    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:    return {imm[31:12], rd, op};
      3'd5:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      3'd6:    return {f7, imm[4:0], rs1, f3, rd, op};
      default: return NOP;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign wr_ok    = wr_en && (state_q == S_IDLE);
  assign wr_word  = encode(wr_fmt, wr_opcode, wr_funct3, wr_funct7, wr_rd, wr_rs1, wr_rs2, wr_imm);
  assign last_idx = ({1'b0, ptr_q} == (count_q - 1'b1));

  always_comb begin
    state_d = state_q;  mem_d   = mem_q;   ptr_d   = ptr_q;   idx_d   = idx_q;
    rep_d   = rep_q;    rep_n_d = rep_n_q; emit_d  = emit_q;  total_d = total_q;
    count_d = count_q;  mode_d  = mode_q;  lfsr_d  = lfsr_q;  instr_d = instr_q;
    valid_d = valid_q;  done_d  = 1'b0;    err_d   = err_q;
    if (wr_ok) mem_d[wr_addr] = wr_word;
    case (state_q)
      S_IDLE: if (start) begin
        err_d   = 1'b0;
        count_d = count;
        mode_d  = mode;
        rep_n_d = repeat_n;
        total_d = EW'(count) * EW'({1'b0, repeat_n} + 1'b1);
        if (count == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          ptr_d  = '0;
          rep_d  = '0;
          emit_d = '0;
          lfsr_d = LFSR_SEED;
          if (mode == 2'd2) begin
            state_d = S_SEEK;
          end else begin
            // mem_d already carries a same-cycle write, so entry 0 is forwarded
            state_d = S_RUN;
            valid_d = 1'b1;
            idx_d   = '0;
            instr_d = mem_d[0];
          end
        end
      end
      S_RUN: if (instr_ready_i) begin
        emit_d = emit_q + 1'b1;
        if (mode_q == 2'd2) begin
          valid_d = 1'b0;
          if (emit_q + 1'b1 == total_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEEK;
          end
        end else if (!last_idx) begin
          ptr_d   = ptr_q + 1'b1;
          idx_d   = ptr_q + 1'b1;
          instr_d = mem_q[ptr_q + 1'b1];
        end else if (mode_q == 2'd1 && rep_q != rep_n_q) begin
          rep_d   = rep_q + 1'b1;
          ptr_d   = '0;
          idx_d   = '0;
          instr_d = mem_q[0];
        end else begin
          state_d = S_DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_SEEK: begin
        lfsr_d = lfsr_step(lfsr_q);
        if ({1'b0, lfsr_q[AW-1:0]} < count_q) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          ptr_d   = lfsr_q[AW-1:0];
          idx_d   = lfsr_q[AW-1:0];
          instr_d = mem_q[lfsr_q[AW-1:0]];
        end
      end
      default: state_d = S_IDLE;
    endcase
    // raised after the start clear so a bad write in the start cycle still flags
    if (wr_en && (!wr_ok || wr_fmt == 3'd7)) err_d = 1'b1;
    if (wr_ok && wr_fmt == 3'd7) mem_d[wr_addr] = NOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP;
      ptr_q   <= '0;  idx_q   <= '0;  rep_q   <= '0;  rep_n_q <= '0;
      emit_q  <= '0;  total_q <= '0;  count_q <= '0;  mode_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      instr_q <= '0;  valid_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;   idx_q   <= idx_d;   rep_q   <= rep_d;   rep_n_q <= rep_n_d;
      emit_q  <= emit_d;  total_q <= total_d; count_q <= count_d; mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      instr_q <= instr_d; valid_q <= valid_d; done_q  <= done_d;  err_q   <= err_d;
    end
  end

  assign instr_o       = instr_q;
  assign instr_idx_o   = idx_q;
  assign instr_valid_o = valid_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_rv_instr_stream_gen.sv
// Directed-plus-random bench for rv_instr_stream_gen, checked against a field-level
// encoder model, a program-order model and an LFSR index model.
module tb_rv_instr_stream_gen;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [2:0]  wr_fmt = '0, wr_funct3 = '0;
  logic [6:0]  wr_opcode = '0, wr_funct7 = '0;
  logic [4:0]  wr_rd = '0, wr_rs1 = '0, wr_rs2 = '0;
  logic [31:0] wr_imm = '0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [4:0]  count = '0;
  logic [7:0]  repeat_n = '0;
  logic [31:0] instr_o;
  logic [3:0]  instr_idx_o;
  logic        instr_valid_o, busy_o, done_o, err_o;
  logic        instr_ready_i = 1'b0;

  int nchk = 0, nfail = 0;
  logic [31:0] mdl_mem [DEPTH];
  int          hs_idx[$], exp_idx[$], first_rand[$];
  logic [31:0] hs_ins[$];

  rv_instr_stream_gen dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fmt(wr_fmt),
    .wr_opcode(wr_opcode), .wr_funct3(wr_funct3), .wr_funct7(wr_funct7),
    .wr_rd(wr_rd), .wr_rs1(wr_rs1), .wr_rs2(wr_rs2), .wr_imm(wr_imm),
    .start(start), .mode(mode), .count(count), .repeat_n(repeat_n),
    .instr_o(instr_o), .instr_idx_o(instr_idx_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // RV32 field packing written straight from the instruction formats
  function automatic logic [31:0] enc(input int f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    case (f)
      0: return {f7, rs2, rs1, f3, rd, op};
      1: return {imm[11:0], rs1, f3, rd, op};
      2: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      4: return {imm[31:12], rd, op};
      5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      6: return {f7, imm[4:0], rs1, f3, rd, op};
      default: return NOP;
    endcase
  endfunction

  task automatic set_wr(input int addr, input int f, input int op, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input logic [31:0] imm, input bit commit);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_fmt = 3'(f); wr_opcode = 7'(op);
    wr_funct3 = 3'(f3); wr_funct7 = 7'(f7); wr_rd = 5'(rd); wr_rs1 = 5'(rs1);
    wr_rs2 = 5'(rs2); wr_imm = imm;
    if (commit) mdl_mem[addr] = enc(f, 7'(op), 3'(f3), 7'(f7), 5'(rd), 5'(rs1), 5'(rs2), imm);
  endtask

  task automatic wr(input int addr, input int f, input int op, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    set_wr(addr, f, op, f3, f7, rd, rs1, rs2, imm, 1'b1);
    tick;
    wr_en = 1'b0;
  endtask

  // Expected index order from the playback rules
  task automatic build_exp(input int md, input int cnt, input int rep);
    logic [15:0] l;
    int cand;
    exp_idx.delete();
    if (md == 1) begin
      for (int r = 0; r <= rep; r++) for (int i = 0; i < cnt; i++) exp_idx.push_back(i);
    end else if (md == 2) begin
      l = 16'hACE1;
      for (int k = 0; k < cnt * (rep + 1); k++) begin
        do begin
          cand = int'(l) % DEPTH;
          l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end while (cand >= cnt);
        exp_idx.push_back(cand);
      end
    end else begin
      for (int i = 0; i < cnt; i++) exp_idx.push_back(i);
    end
  endtask

  // rdy: 0 = always ready, 1 = toggle 1/0, 2 = random
  task automatic play(input string tag, input int md, input int cnt, input int rep, input int rdy);
    int cyc = 0, last_hs = -1;
    bit got_done = 1'b0, stall = 1'b0;
    logic [31:0] p_ins = '0;
    logic [3:0]  p_idx = '0;
    hs_idx.delete(); hs_ins.delete();
    start = 1'b1; mode = 2'(md); count = 5'(cnt); repeat_n = 8'(rep);
    tick;
    start = 1'b0; wr_en = 1'b0;
    while (cyc < 3000) begin
      if (done_o) begin got_done = 1'b1; break; end
      instr_ready_i = (rdy == 0) ? 1'b1 : (rdy == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (stall && instr_valid_o) begin
        chk({tag, "_hold_instr"}, instr_o, p_ins);
        chk({tag, "_hold_idx"}, 32'(instr_idx_o), 32'(p_idx));
      end
      if (instr_valid_o && instr_ready_i) begin
        hs_idx.push_back(int'(instr_idx_o)); hs_ins.push_back(instr_o); last_hs = cyc;
      end
      stall = instr_valid_o && !instr_ready_i; p_ins = instr_o; p_idx = instr_idx_o;
      tick; cyc++;
    end
    instr_ready_i = 1'b1;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_done_timing"}, cyc, last_hs + 1);
    chk({tag, "_done_valid_low"}, 32'(instr_valid_o), 32'd0);
    build_exp(md, cnt, rep);
    chk({tag, "_hs_count"}, hs_idx.size(), exp_idx.size());
    for (int i = 0; i < hs_idx.size() && i < exp_idx.size(); i++) begin
      chk({tag, "_idx"}, hs_idx[i], exp_idx[i]);
      chk({tag, "_instr"}, hs_ins[i], mdl_mem[exp_idx[i]]);
    end
    tick;
    chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_idle_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    logic [31:0] exp5 [5];
    bit got;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;

    // reset state
    tick; tick; tick;
    chk("rst_valid", 32'(instr_valid_o), 0); chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);         chk("rst_err", 32'(err_o), 0);
    chk("rst_instr", instr_o, 0);            chk("rst_idx", 32'(instr_idx_o), 0);
    rst = 1'b0;
    tick;
    play("rst_nops", 0, 16, 0, 0);

    // single addi x20,x0,5
    wr(0, 1, 'h13, 0, 0, 20, 0, 0, 32'd5);
    play("addi", 0, 1, 0, 0);
    chk("addi_word", hs_ins[0], 32'h00500A13);

    // one of each remaining format
    wr(0, 5, 'h6F, 0, 0, 1, 0, 0, 32'd2);
    wr(1, 2, 'h23, 2, 0, 0, 0, 2, 32'd8);
    wr(2, 3, 'h63, 0, 0, 0, 1, 2, -32'sd4);
    wr(3, 0, 'h33, 0, 1, 1, 2, 3, 32'd0);
    wr(4, 6, 'h13, 5, 'h20, 24, 5, 0, 32'd5);
    play("fmts", 0, 5, 0, 0);
    exp5 = '{32'h002000EF, 32'h00202423, 32'hFE208EE3, 32'h023100B3, 32'h4052DC13};
    for (int i = 0; i < 5 && i < hs_ins.size(); i++) chk("fmts_const", hs_ins[i], exp5[i]);

    play("loop", 1, 3, 2, 1);
    play("rand_a", 2, 5, 0, 0);
    first_rand = hs_idx;
    play("rand_b", 2, 5, 0, 2);
    chk("rand_len", hs_idx.size(), first_rand.size());
    for (int i = 0; i < hs_idx.size() && i < first_rand.size(); i++)
      chk("rand_repeat", hs_idx[i], first_rand[i]);
    play("rand_rep", 2, 7, 1, 2);
    play("mode3", 3, 4, 5, 2);
    play("count0", 0, 0, 0, 0);

    // random fields, random ready
    for (int i = 0; i < DEPTH; i++)
      wr(i, $urandom_range(0, 6), $urandom_range(0, 127), $urandom_range(0, 7),
         $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom);
    play("rand_fields", 0, 16, 0, 2);
    play("rand_loop", 1, 1 + $urandom_range(0, 15), $urandom_range(0, 3), 2);

    // write in the start cycle is used by playback
    set_wr(0, 4, 'h37, 0, 0, 7, 0, 0, 32'hDEAD_B000, 1'b1);
    play("wr_start", 0, 2, 0, 0);

    // illegal format, then a dropped write while busy
    wr(2, 7, 'h33, 0, 0, 1, 1, 1, 32'd0);
    mdl_mem[2] = NOP;
    chk("err_fmt7", 32'(err_o), 1);
    tick; tick;
    chk("err_sticky", 32'(err_o), 1);
    start = 1'b1; mode = 2'd1; count = 5'd3; repeat_n = 8'd2; instr_ready_i = 1'b1;
    tick;
    start = 1'b0;
    chk("err_clr_start", 32'(err_o), 0);
    set_wr(1, 0, 'h33, 0, 0, 9, 9, 9, 32'd0, 1'b0);
    tick;
    wr_en = 1'b0;
    chk("err_busy_wr", 32'(err_o), 1);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (done_o) got = 1'b1; else tick;
    end
    chk("err_run_done", 32'(got), 1);
    tick; tick;
    chk("err_after_done", 32'(err_o), 1);
    play("err_readback", 0, 3, 0, 0);
    chk("err_cleared", 32'(err_o), 0);

    // reset mid-loop
    start = 1'b1; mode = 2'd1; count = 5'd3; repeat_n = 8'd5;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_valid", 32'(instr_valid_o), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done_o) got = 1'b1;
      tick;
    end
    chk("mrst_no_done", 32'(got), 0);
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;
    play("mrst_nops", 0, 16, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/rv_instr_stream_gen.md
Name: rv_instr_stream_gen

Overview:
- Parametrised RV32IM instruction stimulus source for core-level benches. It is the sequential successor to the static hand-encoded instruction constants.
- Software or the bench loads instruction fields (format, opcode, funct3/funct7, registers, immediate) through a write port. The block encodes each entry to a 32-bit word and stores it in a DEPTH-entry program buffer.
- The buffer is replayed into the fetch/decode path over a valid/ready stream in sequential, looped or pseudo-random order.

Parameters:
- DEPTH, 16, program buffer entries; power of two, at least 2. AW = log2(DEPTH).
- REPEAT_W, 8, width of the loop/repeat counter.
- LFSR_SEED, 16'hACE1, non-zero seed loaded into the random-mode LFSR on every start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write one program entry
- wr_addr  in  AW  entry index
- wr_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SHIFT-imm 7=illegal
- wr_opcode  in  7  opcode
- wr_funct3  in  3  funct3
- wr_funct7  in  7  funct7
- wr_rd, wr_rs1, wr_rs2  in  5 each  register fields
- wr_imm  in  32  immediate (byte offset for B/J)
- start  in  1  begin playback
- mode  in  2  0=sequential 1=loop 2=random 3=reserved (treated as sequential)
- count  in  AW+1  entries to use (0..DEPTH)
- repeat_n  in  REPEAT_W  extra passes (loop and random modes)
- instr_o  out  32  encoded instruction
- instr_idx_o  out  AW  buffer index of instr_o
- instr_valid_o  out  1  stream valid
- instr_ready_i  in  1  stream ready
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag

Behaviour:
- Reset: clk-synchronous, active-high rst. FSM goes to IDLE. All outputs are 0, except that instr_o and instr_idx_o are also 0. Every buffer entry is set to NOP 32'h0000_0013. LFSR is set to LFSR_SEED. Reset asserted mid-run aborts playback immediately with no done_o pulse.
- Encode on write: a write is accepted only in IDLE, and the entry is readable on the next cycle. Field packing:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - SHIFT: {f7,imm[4:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Unused immediate bits are ignored.
- Write errors: fmt=7 stores NOP and sets err_o. A write while busy_o=1 is dropped and sets err_o. err_o clears only on an accepted start or on rst.
- FSM states: IDLE, RUN, SEEK (random index search), DONE.
- IDLE:
  - start with count>0: clear ptr/rep/emit counters, reseed LFSR, go to RUN (random mode goes to SEEK). instr_valid_o rises on the following cycle.
  - start with count=0: go to DONE, so done_o pulses with no output.
  - start outside IDLE is ignored.
- RUN: instr_valid_o=1 and instr_o/instr_idx_o are registered from mem[ptr]. They must hold stable while instr_ready_i=0. A handshake advances to the next entry with zero bubbles.
- Sequential order: 0..count-1, then DONE.
- Loop mode: after index count-1, if rep==repeat_n go to DONE; otherwise rep+1 and ptr wraps to 0. Total emitted = count*(repeat_n+1).
- Random mode:
  - 16-bit Galois LFSR, taps mask 16'hB400, steps once per cycle in SEEK.
  - Candidate = lfsr[AW-1:0]. If candidate >= count, stay in SEEK with valid low; otherwise load ptr and go to RUN.
  - After each handshake return to SEEK unless emit == count*(repeat_n+1), in which case go to DONE.
- DONE: lasts one cycle with done_o=1 and valid=0, then IDLE. After the final handshake, valid is low on the next cycle and done_o is high on that same cycle.
- start and wr_en in the same IDLE cycle: the write commits and playback uses the new word.

Test Plan:
- Write addr0 {I, op 0x13, f3 0, rd 20, rs1 0, imm 5}, count=1, mode 0, ready=1 -> instr_o=32'h00500A13 one cycle after start, done_o pulses the cycle after the handshake.
- Write J{op 0x6F, rd 1, imm 2}, S{op 0x23, f3 2, rs2 2, rs1 0, imm 8}, B{op 0x63, f3 0, rs1 1, rs2 2, imm -4}, R{op 0x33, f7 1, rs2 3, rs1 2, rd 1}, SHIFT{op 0x13, f3 5, f7 0x20, rs1 5, rd 24, imm 5}; sequential playback -> 002000EF, 00202423, FE208EE3, 023100B3, 4052DC13 in order.
- Loop mode, count=3, repeat_n=2, ready toggling 1/0 -> exactly 9 handshakes with idx 0,1,2 repeated three times; instr_o stable while ready=0.
- Random mode, count=5 -> 5 outputs, every idx <5, and the sequence is identical on a second start (reseed).
- Write with fmt=7, then a write during RUN -> entry reads NOP, err_o=1 and stays set until the next start.
- rst asserted mid-loop -> next cycle valid=0, busy=0, done_o never pulses, all entries read back 00000013.
